riscv_divider: RTL and testbench



---
 rtl/riscv_divider_pkg.sv | 24 ++
 rtl/riscv_divider_if.sv | 24 ++
 rtl/riscv_divider_div_step.sv | 28 ++
 rtl/riscv_divider.sv | 167 ++++++++++++++++
 tb/tb_riscv_divider.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/riscv_divider_pkg.sv
// Shared encodings and helpers for the RV32M iterative divider.
// Optional build macro handled elsewhere: RISCV_DIV_FAST_SPECIAL_EN.
package riscv_divider_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    function automatic logic [XLEN-1:0] negate_if(input logic neg, input logic [XLEN-1:0] value);
        return neg ? (~value + 1'b1) : value;
    endfunction

endpackage

// File: rtl/riscv_divider_if.sv
// Request/response handshake bundle between the execute stage and the divider.
interface riscv_divider_if;
    import riscv_divider_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, op, dividend, divisor, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, dividend, divisor, out_ready,
        output in_ready, out_valid, result
    );

endinterface

// File: rtl/riscv_divider_div_step.sv
// One restoring radix-2 division step on the {rem, quo} pair.
module div_step
    import riscv_divider_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] div_mag,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // The 33-bit subtract keeps the borrow visible even when rem has its MSB set.
    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        diff    = shifted - {1'b0, div_mag};
        if (!diff[XLEN]) begin
            rem_next = diff[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end else begin
            rem_next = shifted[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/riscv_divider.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: FSM, operand registers and sign fixup.
// Build macro RISCV_DIV_FAST_SPECIAL_EN gives divide-by-zero and overflow a 1-cycle path.
module riscv_divider
    import riscv_divider_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    riscv_divider_if.slave  bus
);

    div_state_e      state;
    div_state_e      state_next;
    logic [4:0]      count;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] div_mag;
    logic [XLEN-1:0] rem_step;
    logic [XLEN-1:0] quo_step;
    logic            is_rem;
    logic            neg_q;
    logic            neg_r;
    logic            div_zero;
    logic            ovf;
    logic            out_valid;
    logic [XLEN-1:0] result;

    logic            accept;
    logic            done_calc;
    logic            a_neg;
    logic            b_neg;
    logic            in_zero;
    logic            in_ovf;
    logic [XLEN-1:0] load_val;
`ifdef RISCV_DIV_FAST_SPECIAL_EN
    logic            fast;
`endif

    assign bus.in_ready  = (state == DIV_IDLE);
    assign bus.out_valid = out_valid;
    assign bus.result    = result;
    assign accept        = bus.in_valid && (state == DIV_IDLE);

    div_step u_step (
        .rem      (rem),
        .quo      (quo),
        .div_mag  (div_mag),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    always_comb begin
        a_neg   = !bus.op[0] && bus.dividend[XLEN-1];
        b_neg   = !bus.op[0] && bus.divisor[XLEN-1];
        in_zero = (bus.divisor == '0);
        in_ovf  = !bus.op[0] && (bus.dividend == {1'b1, {(XLEN-1){1'b0}}}) && (bus.divisor == '1);
`ifdef RISCV_DIV_FAST_SPECIAL_EN
        done_calc = (state == DIV_CALC) && (fast || (count == 5'd31));
`else
        done_calc = (state == DIV_CALC) && (count == 5'd31);
`endif
    end

    // Divide-by-zero quotient stays all-ones regardless of operand signs.
    always_comb begin
        if (is_rem) begin
            load_val = negate_if(neg_r, rem_step);
        end else begin
            load_val = negate_if(neg_q && !div_zero, quo_step);
        end
        if (ovf) begin
            load_val = is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
`ifdef RISCV_DIV_FAST_SPECIAL_EN
        if (fast) begin
            load_val = quo;
        end
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            DIV_IDLE: if (accept)        state_next = DIV_CALC;
            DIV_CALC: if (done_calc)     state_next = DIV_DONE;
            DIV_DONE: if (bus.out_ready) state_next = DIV_IDLE;
            default:                     state_next = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            rem       <= '0;
            quo       <= '0;
            div_mag   <= '0;
            is_rem    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
`ifdef RISCV_DIV_FAST_SPECIAL_EN
            fast      <= 1'b0;
`endif
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (accept) begin
                        count    <= '0;
                        rem      <= '0;
                        quo      <= negate_if(a_neg, bus.dividend);
                        div_mag  <= negate_if(b_neg, bus.divisor);
                        is_rem   <= bus.op[1];
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg;
                        div_zero <= in_zero;
                        ovf      <= in_ovf;
`ifdef RISCV_DIV_FAST_SPECIAL_EN
                        // Special results are parked in quo and loaded on the next edge.
                        fast <= in_zero || in_ovf;
                        if (in_zero) begin
                            quo <= bus.op[1] ? bus.dividend : '1;
                        end else if (in_ovf) begin
                            quo <= bus.op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        end
`endif
                    end
                end
                DIV_CALC: begin
`ifdef RISCV_DIV_FAST_SPECIAL_EN
                    if (!fast) begin
                        rem   <= rem_step;
                        quo   <= quo_step;
                        count <= count + 5'd1;
                    end
`else
                    rem   <= rem_step;
                    quo   <= quo_step;
                    count <= count + 5'd1;
`endif
                    if (done_calc) begin
                        result    <= load_val;
                        out_valid <= 1'b1;
                    end
                end
                DIV_DONE: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_divider.sv
// Randomized and directed bench for riscv_divider against an arithmetic reference model.
module tb_riscv_divider;

`ifdef RISCV_DIV_FAST_SPECIAL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          hold;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    riscv_divider_if bus();

    riscv_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] refResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int signed sa;
        int signed sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            2'b00:   return 32'(sa / sb);
            2'b01:   return a / b;
            2'b10:   return 32'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    function automatic bit isSpecial(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] exp;
        logic [31:0] held;
        int          lat;
        int          explat;
        exp    = refResult(op, a, b);
        explat = (FAST && isSpecial(op, a, b)) ? 1 : 32;
        @(negedge clk);
        checkOutput("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.op       = 2'($urandom_range(0, 3));
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput($sformatf("latency op%0d %h/%h", op, a, b), 32'(lat), 32'(explat));
        checkOutput($sformatf("result op%0d %h/%h", op, a, b), bus.result, exp);
        held = bus.result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_result", bus.result, held);
            checkOutput("hold_out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput("in_ready_after", 32'(bus.in_ready), 32'd1);
        checkOutput("out_valid_after", 32'(bus.out_valid), 32'd0);
    endtask

    vec_t vecs[11] = '{
        '{2'b01, 32'd100,        32'd7,          0},
        '{2'b11, 32'd100,        32'd7,          0},
        '{2'b00, 32'hFFFF_FFF9,  32'd2,          0},
        '{2'b10, 32'hFFFF_FFF9,  32'd2,          0},
        '{2'b10, 32'd7,          32'hFFFF_FFFE,  0},
        '{2'b01, 32'd5,          32'd0,          0},
        '{2'b11, 32'd5,          32'd0,          0},
        '{2'b00, 32'hFFFF_FFFB,  32'd0,          0},
        '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  0},
        '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  0},
        '{2'b01, 32'd1000,       32'd10,         10}
    };

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = 2'b00;
        bus.dividend  = '0;
        bus.divisor   = '0;
        rst_n = 1'b0;
        #12;
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset_result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold);

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                3:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            applyStimulus(op, a, b, $urandom_range(0, 3));
        end

        applyStimulus(2'b01, 32'd100, 32'd7, 0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = 2'b01;
        bus.dividend = 32'hFFFF_FFFF;
        bus.divisor  = 32'd3;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("abort_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("abort_result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(2'b01, 32'd9, 32'd3, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
